// File: rtl/vx_tex_issue_agent.sv
// Texture-bus issue agent: tags execute-stage texture instructions with a pending-table
// slot, issues them to the texture unit and matches returning texels back by slot index.
module vx_tex_issue_agent #(
    parameter  int NUM_LANES    = 4,
    parameter  int NUM_WARPS    = 4,
    parameter  int NUM_STAGES   = 2,
    parameter  int UUID_WIDTH   = 44,
    parameter  int PENDING_SIZE = 4,
    localparam int WID_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int STG_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int IDX_W        = $clog2(PENDING_SIZE),
    localparam int TAG_W        = UUID_WIDTH + IDX_W,
    localparam int CNT_W        = $clog2(PENDING_SIZE + 1)
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        exe_valid,
    input  logic [UUID_WIDTH-1:0]       exe_uuid,
    input  logic [WID_W-1:0]            exe_wid,
    input  logic [NUM_LANES-1:0]        exe_tmask,
    input  logic [31:0]                 exe_pc,
    input  logic [4:0]                  exe_rd,
    input  logic [STG_W-1:0]            exe_stage,
    input  logic [2*NUM_LANES*32-1:0]   exe_coords,
    input  logic [NUM_LANES*32-1:0]     exe_lod,
    output logic                        exe_ready,

    output logic                        tex_req_valid,
    output logic [NUM_LANES-1:0]        tex_req_mask,
    output logic [2*NUM_LANES*32-1:0]   tex_req_coords,
    output logic [NUM_LANES*32-1:0]     tex_req_lod,
    output logic [STG_W-1:0]            tex_req_stage,
    output logic [TAG_W-1:0]            tex_req_tag,
    input  logic                        tex_req_ready,

    input  logic                        tex_rsp_valid,
    input  logic [NUM_LANES*32-1:0]     tex_rsp_texels,
    input  logic [TAG_W-1:0]            tex_rsp_tag,
    output logic                        tex_rsp_ready,

    output logic                        commit_valid,
    output logic [UUID_WIDTH-1:0]       commit_uuid,
    output logic [WID_W-1:0]            commit_wid,
    output logic [NUM_LANES-1:0]        commit_tmask,
    output logic [31:0]                 commit_pc,
    output logic [4:0]                  commit_rd,
    output logic [NUM_LANES*32-1:0]     commit_data,
    input  logic                        commit_ready,

    output logic [CNT_W-1:0]            pending_count
);

    logic [PENDING_SIZE-1:0]     free_q, free_d;
    logic [WID_W-1:0]            tbl_wid_q   [PENDING_SIZE];
    logic [WID_W-1:0]            tbl_wid_d   [PENDING_SIZE];
    logic [NUM_LANES-1:0]        tbl_tmask_q [PENDING_SIZE];
    logic [NUM_LANES-1:0]        tbl_tmask_d [PENDING_SIZE];
    logic [31:0]                 tbl_pc_q    [PENDING_SIZE];
    logic [31:0]                 tbl_pc_d    [PENDING_SIZE];
    logic [4:0]                  tbl_rd_q    [PENDING_SIZE];
    logic [4:0]                  tbl_rd_d    [PENDING_SIZE];

    logic                        req_valid_q, req_valid_d;
    logic [NUM_LANES-1:0]        req_mask_q, req_mask_d;
    logic [2*NUM_LANES*32-1:0]   req_coords_q, req_coords_d;
    logic [NUM_LANES*32-1:0]     req_lod_q, req_lod_d;
    logic [STG_W-1:0]            req_stage_q, req_stage_d;
    logic [TAG_W-1:0]            req_tag_q, req_tag_d;

    logic                        commit_valid_q, commit_valid_d;
    logic [UUID_WIDTH-1:0]       commit_uuid_q, commit_uuid_d;
    logic [WID_W-1:0]            commit_wid_q, commit_wid_d;
    logic [NUM_LANES-1:0]        commit_tmask_q, commit_tmask_d;
    logic [31:0]                 commit_pc_q, commit_pc_d;
    logic [4:0]                  commit_rd_q, commit_rd_d;
    logic [NUM_LANES*32-1:0]     commit_data_q, commit_data_d;

    logic [CNT_W-1:0]            count_q, count_d;

    logic                        full;
    logic [IDX_W-1:0]            alloc_idx;
    logic                        exe_fire;
    logic                        rsp_fire;
    logic [IDX_W-1:0]            rsp_slot;

    // Lowest free slot wins; a slot freed this cycle only shows up after the edge.
    always_comb begin
        alloc_idx = '0;
        for (int i = PENDING_SIZE - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign full          = ~|free_q;
    assign exe_ready     = ~reset & ~full & (~req_valid_q | tex_req_ready);
    assign tex_rsp_ready = ~reset & (~commit_valid_q | commit_ready);
    assign exe_fire      = exe_valid & exe_ready;
    assign rsp_fire      = tex_rsp_valid & tex_rsp_ready;
    assign rsp_slot      = tex_rsp_tag[IDX_W-1:0];

    always_comb begin
        free_d         = free_q;
        tbl_wid_d      = tbl_wid_q;
        tbl_tmask_d    = tbl_tmask_q;
        tbl_pc_d       = tbl_pc_q;
        tbl_rd_d       = tbl_rd_q;
        req_valid_d    = req_valid_q;
        req_mask_d     = req_mask_q;
        req_coords_d   = req_coords_q;
        req_lod_d      = req_lod_q;
        req_stage_d    = req_stage_q;
        req_tag_d      = req_tag_q;
        commit_valid_d = commit_valid_q;
        commit_uuid_d  = commit_uuid_q;
        commit_wid_d   = commit_wid_q;
        commit_tmask_d = commit_tmask_q;
        commit_pc_d    = commit_pc_q;
        commit_rd_d    = commit_rd_q;
        commit_data_d  = commit_data_q;
        count_d        = count_q;

        if (exe_fire) begin
            free_d[alloc_idx]      = 1'b0;
            tbl_wid_d[alloc_idx]   = exe_wid;
            tbl_tmask_d[alloc_idx] = exe_tmask;
            tbl_pc_d[alloc_idx]    = exe_pc;
            tbl_rd_d[alloc_idx]    = exe_rd;
            req_valid_d            = 1'b1;
            req_mask_d             = exe_tmask;
            req_coords_d           = exe_coords;
            req_lod_d              = exe_lod;
            req_stage_d            = exe_stage;
            req_tag_d              = {exe_uuid, alloc_idx};
        end else if (tex_req_ready) begin
            req_valid_d = 1'b0;
        end

        // Table read uses pre-edge contents; the uuid travels in the tag itself.
        if (rsp_fire) begin
            free_d[rsp_slot] = 1'b1;
            commit_valid_d   = 1'b1;
            commit_uuid_d    = tex_rsp_tag[TAG_W-1 -: UUID_WIDTH];
            commit_wid_d     = tbl_wid_q[rsp_slot];
            commit_tmask_d   = tbl_tmask_q[rsp_slot];
            commit_pc_d      = tbl_pc_q[rsp_slot];
            commit_rd_d      = tbl_rd_q[rsp_slot];
            commit_data_d    = tex_rsp_texels;
        end else if (commit_ready) begin
            commit_valid_d = 1'b0;
        end

        if (exe_fire && !rsp_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!exe_fire && rsp_fire && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_q         <= '1;
            req_valid_q    <= 1'b0;
            commit_valid_q <= 1'b0;
            count_q        <= '0;
        end else begin
            free_q         <= free_d;
            req_valid_q    <= req_valid_d;
            commit_valid_q <= commit_valid_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        tbl_wid_q      <= tbl_wid_d;
        tbl_tmask_q    <= tbl_tmask_d;
        tbl_pc_q       <= tbl_pc_d;
        tbl_rd_q       <= tbl_rd_d;
        req_mask_q     <= req_mask_d;
        req_coords_q   <= req_coords_d;
        req_lod_q      <= req_lod_d;
        req_stage_q    <= req_stage_d;
        req_tag_q      <= req_tag_d;
        commit_uuid_q  <= commit_uuid_d;
        commit_wid_q   <= commit_wid_d;
        commit_tmask_q <= commit_tmask_d;
        commit_pc_q    <= commit_pc_d;
        commit_rd_q    <= commit_rd_d;
        commit_data_q  <= commit_data_d;
    end

    assign tex_req_valid  = req_valid_q;
    assign tex_req_mask   = req_mask_q;
    assign tex_req_coords = req_coords_q;
    assign tex_req_lod    = req_lod_q;
    assign tex_req_stage  = req_stage_q;
    assign tex_req_tag    = req_tag_q;
    assign commit_valid   = commit_valid_q;
    assign commit_uuid    = commit_uuid_q;
    assign commit_wid     = commit_wid_q;
    assign commit_tmask   = commit_tmask_q;
    assign commit_pc      = commit_pc_q;
    assign commit_rd      = commit_rd_q;
    assign commit_data    = commit_data_q;
    assign pending_count  = count_q;

    a_no_alloc_full: assert property (@(posedge clk) disable iff (reset) !(exe_fire && full));
    a_rsp_to_busy:   assert property (@(posedge clk) disable iff (reset) !(rsp_fire && free_q[rsp_slot]));
    a_no_underflow:  assert property (@(posedge clk) disable iff (reset) !(rsp_fire && count_q == '0));

endmodule

// File: tb/tb_vx_tex_issue_agent.sv
// Bench for vx_tex_issue_agent: per-cycle vector table for handshakes and occupancy,
// plus a scoreboard that checks every request and commit payload against queued expectations.
module tb_vx_tex_issue_agent;

    logic         clk = 1'b0;
    logic         reset;
    logic         exe_valid;
    logic [43:0]  exe_uuid;
    logic [1:0]   exe_wid;
    logic [3:0]   exe_tmask;
    logic [31:0]  exe_pc;
    logic [4:0]   exe_rd;
    logic         exe_stage;
    logic [255:0] exe_coords;
    logic [127:0] exe_lod;
    logic         exe_ready;
    logic         tex_req_valid;
    logic [3:0]   tex_req_mask;
    logic [255:0] tex_req_coords;
    logic [127:0] tex_req_lod;
    logic         tex_req_stage;
    logic [45:0]  tex_req_tag;
    logic         tex_req_ready;
    logic         tex_rsp_valid;
    logic [127:0] tex_rsp_texels;
    logic [45:0]  tex_rsp_tag;
    logic         tex_rsp_ready;
    logic         commit_valid;
    logic [43:0]  commit_uuid;
    logic [1:0]   commit_wid;
    logic [3:0]   commit_tmask;
    logic [31:0]  commit_pc;
    logic [4:0]   commit_rd;
    logic [127:0] commit_data;
    logic         commit_ready;
    logic [2:0]   pending_count;

    vx_tex_issue_agent dut (
        .clk(clk), .reset(reset),
        .exe_valid(exe_valid), .exe_uuid(exe_uuid), .exe_wid(exe_wid), .exe_tmask(exe_tmask),
        .exe_pc(exe_pc), .exe_rd(exe_rd), .exe_stage(exe_stage), .exe_coords(exe_coords),
        .exe_lod(exe_lod), .exe_ready(exe_ready),
        .tex_req_valid(tex_req_valid), .tex_req_mask(tex_req_mask), .tex_req_coords(tex_req_coords),
        .tex_req_lod(tex_req_lod), .tex_req_stage(tex_req_stage), .tex_req_tag(tex_req_tag),
        .tex_req_ready(tex_req_ready),
        .tex_rsp_valid(tex_rsp_valid), .tex_rsp_texels(tex_rsp_texels), .tex_rsp_tag(tex_rsp_tag),
        .tex_rsp_ready(tex_rsp_ready),
        .commit_valid(commit_valid), .commit_uuid(commit_uuid), .commit_wid(commit_wid),
        .commit_tmask(commit_tmask), .commit_pc(commit_pc), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_ready(commit_ready),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        do_exe;
        logic [43:0] uuid;
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        stage;
        logic [1:0]  exp_slot;
        logic        do_rsp;
        logic [1:0]  rsp_slot;
        logic [31:0] texel0;
        logic        req_rdy;
        logic        cmt_rdy;
        logic        exp_ready;
        logic [2:0]  exp_count;
        logic        exp_req_v;
        logic        exp_cmt_v;
    } vec_t;

    typedef struct packed {
        logic [45:0]  tag;
        logic [3:0]   mask;
        logic         stage;
        logic [255:0] coords;
        logic [127:0] lod;
    } exp_req_t;

    typedef struct packed {
        logic [43:0]  uuid;
        logic [1:0]   wid;
        logic [3:0]   tmask;
        logic [31:0]  pc;
        logic [4:0]   rd;
        logic [127:0] data;
    } exp_cmt_t;

    int checks = 0;
    int errors = 0;

    exp_req_t    req_q[$];
    exp_cmt_t    cmt_q[$];
    logic [43:0] sh_uuid  [4];
    logic [1:0]  sh_wid   [4];
    logic [3:0]  sh_tmask [4];
    logic [31:0] sh_pc    [4];
    logic [4:0]  sh_rd    [4];
    logic [1:0]  cur_exp_slot;
    vec_t        vecs [17];
    logic [45:0]  saved_tag;
    logic [255:0] saved_coords;
    logic [127:0] saved_data;
    logic [43:0]  saved_uuid;

    task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit de, input int uuid, input int wid, input int tm,
                                input int pc, input int rd, input int st, input int slot,
                                input bit dr, input int rslot, input int tex,
                                input bit rr, input bit cr, input bit er, input int ec,
                                input bit erq, input bit ecm);
        vec_t v;
        v.do_exe    = de;
        v.uuid      = 44'(uuid);
        v.wid       = 2'(wid);
        v.tmask     = 4'(tm);
        v.pc        = 32'(pc);
        v.rd        = 5'(rd);
        v.stage     = 1'(st);
        v.exp_slot  = 2'(slot);
        v.do_rsp    = dr;
        v.rsp_slot  = 2'(rslot);
        v.texel0    = 32'(tex);
        v.req_rdy   = rr;
        v.cmt_rdy   = cr;
        v.exp_ready = er;
        v.exp_count = 3'(ec);
        v.exp_req_v = erq;
        v.exp_cmt_v = ecm;
        return v;
    endfunction

    task automatic checkOutput(input vec_t v);
        check_val("exe_ready", 256'(exe_ready), 256'(v.exp_ready));
        check_val("pending_count", 256'(pending_count), 256'(v.exp_count));
        check_val("tex_req_valid", 256'(tex_req_valid), 256'(v.exp_req_v));
        check_val("commit_valid", 256'(commit_valid), 256'(v.exp_cmt_v));
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [255:0] c;
        @(negedge clk);
        for (int i = 0; i < 8; i++) c[i*32 +: 32] = $urandom;
        c[63:0]        = {32'h0000_0200, 32'h0000_0100};
        reset          = 1'b0;
        exe_valid      = v.do_exe;
        exe_uuid       = v.uuid;
        exe_wid        = v.wid;
        exe_tmask      = v.tmask;
        exe_pc         = v.pc;
        exe_rd         = v.rd;
        exe_stage      = v.stage;
        exe_coords     = c;
        exe_lod        = {$urandom, $urandom, $urandom, $urandom};
        cur_exp_slot   = v.exp_slot;
        tex_req_ready  = v.req_rdy;
        commit_ready   = v.cmt_rdy;
        tex_rsp_valid  = v.do_rsp;
        tex_rsp_tag    = {sh_uuid[v.rsp_slot], v.rsp_slot};
        tex_rsp_texels = {v.texel0 ^ 32'hA5A5_A5A5, ~v.texel0, v.texel0 + 32'd1, v.texel0};
        #1;
        checkOutput(v);
    endtask

    // Scoreboard: sampled just before each rising edge, when all handshakes are settled.
    initial begin
        exp_req_t er;
        exp_cmt_t ec;
        logic [1:0] s;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                req_q.delete();
                cmt_q.delete();
            end else begin
                if (tex_req_valid && tex_req_ready) begin
                    if (req_q.size() == 0) begin
                        check_val("unexpected_req", 256'(tex_req_tag), 256'(0));
                    end else begin
                        er = req_q.pop_front();
                        check_val("req_tag", 256'(tex_req_tag), 256'(er.tag));
                        check_val("req_mask", 256'(tex_req_mask), 256'(er.mask));
                        check_val("req_stage", 256'(tex_req_stage), 256'(er.stage));
                        check_val("req_coords", tex_req_coords, er.coords);
                        check_val("req_lod", 256'(tex_req_lod), 256'(er.lod));
                    end
                end
                if (commit_valid && commit_ready) begin
                    if (cmt_q.size() == 0) begin
                        check_val("unexpected_commit", 256'(commit_uuid), 256'(0));
                    end else begin
                        ec = cmt_q.pop_front();
                        check_val("commit_uuid", 256'(commit_uuid), 256'(ec.uuid));
                        check_val("commit_wid", 256'(commit_wid), 256'(ec.wid));
                        check_val("commit_tmask", 256'(commit_tmask), 256'(ec.tmask));
                        check_val("commit_pc", 256'(commit_pc), 256'(ec.pc));
                        check_val("commit_rd", 256'(commit_rd), 256'(ec.rd));
                        check_val("commit_data", 256'(commit_data), 256'(ec.data));
                    end
                end
                if (tex_rsp_valid && tex_rsp_ready) begin
                    s        = tex_rsp_tag[1:0];
                    ec.uuid  = sh_uuid[s];
                    ec.wid   = sh_wid[s];
                    ec.tmask = sh_tmask[s];
                    ec.pc    = sh_pc[s];
                    ec.rd    = sh_rd[s];
                    ec.data  = tex_rsp_texels;
                    cmt_q.push_back(ec);
                end
                if (exe_valid && exe_ready) begin
                    er.tag    = {exe_uuid, cur_exp_slot};
                    er.mask   = exe_tmask;
                    er.stage  = exe_stage;
                    er.coords = exe_coords;
                    er.lod    = exe_lod;
                    req_q.push_back(er);
                    sh_uuid[cur_exp_slot]  = exe_uuid;
                    sh_wid[cur_exp_slot]   = exe_wid;
                    sh_tmask[cur_exp_slot] = exe_tmask;
                    sh_pc[cur_exp_slot]    = exe_pc;
                    sh_rd[cur_exp_slot]    = exe_rd;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            sh_uuid[i] = '0; sh_wid[i] = '0; sh_tmask[i] = '0; sh_pc[i] = '0; sh_rd[i] = '0;
        end
        reset = 1'b1; exe_valid = 1'b0; exe_uuid = '0; exe_wid = '0; exe_tmask = '0;
        exe_pc = '0; exe_rd = '0; exe_stage = 1'b0; exe_coords = '0; exe_lod = '0;
        tex_req_ready = 1'b1; tex_rsp_valid = 1'b0; tex_rsp_texels = '0; tex_rsp_tag = '0;
        commit_ready = 1'b1; cur_exp_slot = '0;

        // Single op, fill to full, blocked 5th op, same-cycle free at full, out-of-order returns.
        vecs[0]  = mk(1, 5, 1, 'b1011, 'h1000, 7, 0, 0,  0, 0, 0,           1, 1,  1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,            1, 0, 'hFF00FF00,  1, 1,  1, 1, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0,           1, 1,  1, 0, 0, 1);
        vecs[3]  = mk(1, 10, 0, 'b1111, 'h2000, 1, 1, 0, 0, 0, 0,           1, 1,  1, 0, 0, 0);
        vecs[4]  = mk(1, 11, 1, 'b0001, 'h2004, 2, 0, 1, 0, 0, 0,           1, 1,  1, 1, 1, 0);
        vecs[5]  = mk(1, 12, 2, 'b0110, 'h2008, 3, 1, 2, 0, 0, 0,           1, 1,  1, 2, 1, 0);
        vecs[6]  = mk(1, 13, 3, 'b1000, 'h200C, 4, 0, 3, 0, 0, 0,           1, 1,  1, 3, 1, 0);
        vecs[7]  = mk(1, 14, 2, 'b1100, 'h2010, 5, 1, 1, 0, 0, 0,           1, 1,  0, 4, 1, 0);
        vecs[8]  = mk(1, 14, 2, 'b1100, 'h2010, 5, 1, 1, 1, 1, 'h11110001,  1, 1,  0, 4, 0, 0);
        vecs[9]  = mk(1, 14, 2, 'b1100, 'h2010, 5, 1, 1, 0, 0, 0,           1, 1,  1, 3, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,            1, 2, 'h22220002,  1, 1,  0, 4, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,            1, 0, 'h33330003,  1, 1,  1, 3, 0, 1);
        vecs[12] = mk(1, 20, 3, 'b0000, 'h2020, 31, 0, 0, 1, 3, 'h44440004, 1, 1,  1, 2, 0, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,            1, 1, 'h55550005,  1, 1,  1, 2, 1, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,            1, 0, 'h66660006,  1, 1,  1, 1, 0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0,           1, 1,  1, 0, 0, 1);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0,           1, 1,  1, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        check_val("reset_exe_ready", 256'(exe_ready), 256'(0));
        check_val("reset_rsp_ready", 256'(tex_rsp_ready), 256'(0));
        check_val("reset_req_valid", 256'(tex_req_valid), 256'(0));
        check_val("reset_commit_valid", 256'(commit_valid), 256'(0));
        check_val("reset_count", 256'(pending_count), 256'(0));

        for (int i = 0; i < 17; i++) applyStimulus(vecs[i]);

        // Request backpressure: fields hold and exe stalls while the unit is not ready.
        applyStimulus(mk(1, 30, 2, 'b1111, 'h3000, 3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        applyStimulus(mk(1, 31, 0, 'b0101, 'h3004, 9, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        saved_tag = tex_req_tag;
        saved_coords = tex_req_coords;
        check_val("stall_tag_value", 256'(tex_req_tag), 256'({44'd30, 2'd0}));
        for (int k = 0; k < 2; k++) begin
            applyStimulus(mk(1, 31, 0, 'b0101, 'h3004, 9, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0));
            check_val("stall_tag_stable", 256'(tex_req_tag), 256'(saved_tag));
            check_val("stall_coords_stable", tex_req_coords, saved_coords);
        end
        applyStimulus(mk(1, 31, 0, 'b0101, 'h3004, 9, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 1, 0));

        // Commit backpressure: response port closes and the commit holds until accepted.
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h12345678, 1, 0, 1, 2, 0, 0));
        check_val("rsp_ready_open", 256'(tex_rsp_ready), 256'(1));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h9ABCDEF0, 1, 0, 1, 1, 0, 1));
        check_val("rsp_ready_blocked", 256'(tex_rsp_ready), 256'(0));
        saved_data = commit_data;
        saved_uuid = commit_uuid;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h9ABCDEF0, 1, 0, 1, 1, 0, 1));
        check_val("rsp_ready_still_blocked", 256'(tex_rsp_ready), 256'(0));
        check_val("commit_data_stable", 256'(commit_data), 256'(saved_data));
        check_val("commit_uuid_stable", 256'(commit_uuid), 256'(saved_uuid));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h9ABCDEF0, 1, 1, 1, 1, 0, 1));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));

        // Reset with two in flight, a stuck request and a stuck commit.
        applyStimulus(mk(1, 40, 1, 'b0011, 'h4000, 10, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        applyStimulus(mk(1, 41, 2, 'b0111, 'h4004, 11, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0));
        applyStimulus(mk(1, 42, 3, 'b1110, 'h4008, 12, 0, 2, 1, 0, 'h0BADC0DE, 1, 0, 1, 2, 1, 0));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1));
        @(negedge clk);
        reset = 1'b1;
        exe_valid = 1'b1;
        tex_rsp_valid = 1'b1;
        #1;
        check_val("midreset_exe_ready", 256'(exe_ready), 256'(0));
        check_val("midreset_rsp_ready", 256'(tex_rsp_ready), 256'(0));
        applyStimulus(mk(1, 50, 0, 'b1001, 'h5000, 13, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hCAFEF00D, 1, 1, 1, 1, 1, 0));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));

        repeat (2) @(negedge clk);
        #1;
        check_val("req_queue_drained", 256'(req_q.size()), 256'(0));
        check_val("commit_queue_drained", 256'(cmt_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_tex_issue_agent.md
Name: vx_tex_issue_agent

Overview:
Core-side initiator for the texture bus. It accepts texture-sample instructions from the execute stage and issues tagged requests to the texture unit. It tracks in-flight instructions in a pending table and matches returning texel responses by tag. Matched results go to writeback/commit. It sits between the SFU dispatch and the texture unit's request/response ports.

Parameters:
NUM_LANES, 4, threads per request
NUM_WARPS, 4, warps per core; WID_W = max(1, clog2(NUM_WARPS))
NUM_STAGES, 2, texture stages; STG_W = max(1, clog2(NUM_STAGES))
UUID_WIDTH, 44, instruction UUID width
PENDING_SIZE, 4, max in-flight requests (power of 2, >=2); IDX_W = clog2(PENDING_SIZE)
TAG_W (derived), UUID_WIDTH+IDX_W, bus tag = {uuid, slot}

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
exe_valid  in  1  instruction valid
exe_uuid  in  UUID_WIDTH  instruction id
exe_wid  in  WID_W  warp id
exe_tmask  in  NUM_LANES  thread mask
exe_pc  in  32  instruction PC
exe_rd  in  5  destination register
exe_stage  in  STG_W  texture stage
exe_coords  in  2*NUM_LANES*32  {v,u} per lane
exe_lod  in  NUM_LANES*32  per-lane lod
exe_ready  out  1  instruction accepted
tex_req_valid  out  1  request valid
tex_req_mask  out  NUM_LANES  = stored tmask
tex_req_coords  out  2*NUM_LANES*32  coords
tex_req_lod  out  NUM_LANES*32  lod
tex_req_stage  out  STG_W  stage
tex_req_tag  out  TAG_W  {uuid, slot}
tex_req_ready  in  1  unit accepts
tex_rsp_valid  in  1  response valid
tex_rsp_texels  in  NUM_LANES*32  texels
tex_rsp_tag  in  TAG_W  echoed tag
tex_rsp_ready  out  1  response accepted
commit_valid  out  1  writeback valid
commit_uuid  out  UUID_WIDTH; commit_wid out WID_W; commit_tmask out NUM_LANES; commit_pc out 32; commit_rd out 5
commit_data  out  NUM_LANES*32  texels
commit_ready  in  1  writeback accepts
pending_count  out  clog2(PENDING_SIZE+1)  allocated slots

Behaviour:
- Reset: all slots free, tex_req_valid=0, commit_valid=0, pending_count=0. exe_ready=0 and tex_rsp_ready=0 while reset is high. Other outputs have don't-care values while their valid is low.
- Pending table: PENDING_SIZE entries of {wid, tmask, pc, rd} plus a free bitmask.
- full = no free slot. alloc_idx = lowest-index free slot (priority encoder on the pre-edge mask).
- exe_ready = ~reset & ~full & (~tex_req_valid | tex_req_ready).
- Request stage is one registered slot. On exe fire:
  - table[alloc_idx] is written.
  - the free bit is cleared.
  - request registers are loaded with tag = {exe_uuid, alloc_idx}.
  - tex_req_valid rises the next cycle. Latency is 1 cycle.
- Back-to-back: with tex_req_ready held high, one request per cycle is accepted.
- tex_req_* holds stable while valid & ~ready.
- tex_rsp_ready = ~reset & (~commit_valid | commit_ready).
- On rsp fire:
  - slot = tex_rsp_tag[IDX_W-1:0].
  - commit registers are loaded from table[slot], commit_uuid = tag[TAG_W-1 -: UUID_WIDTH], commit_data = texels.
  - commit_valid rises the next cycle.
  - the slot's free bit is set at the same edge.
- Commit output holds stable while valid & ~ready.
- Responses may return in any order; each is matched purely by slot index.
- Simultaneous alloc and free in one cycle:
  - allocation uses the pre-edge mask, so a slot freed this cycle is allocatable only from the next cycle.
  - pending_count is unchanged (+1 -1).
  - at full, exe_ready stays 0 that cycle even though a free occurs.
- pending_count = +1 on exe fire, -1 on rsp fire, never wraps. Simulation assertions:
  - no alloc when full;
  - no response to a free slot (the commit still issues, with stale table contents);
  - no count underflow.
- tmask=0 is forwarded unchanged; there is no special casing.
- Reset mid-operation discards all in-flight entries and both output registers. The environment must not deliver stale-tag responses after reset.
- No combinational path from tex_rsp_valid to exe_ready, or from tex_req_ready to tex_rsp_ready.

Test Plan:
- Single op: exe uuid=5, wid=1, tmask=4'b1011, rd=7, coords lane0=(0x100,0x200) -> next cycle tex_req_tag={5,0}, mask=1011. Then rsp tag={5,0}, texels lane0=0xFF00FF00 -> next cycle commit_valid=1, wid=1, rd=7, data lane0=0xFF00FF00; pending_count goes 1 then 0.
- Fill: 4 exe ops with tex_rsp_valid=0 -> tags use slots 0,1,2,3, pending_count=4, exe_ready=0 on the 5th op until a response fires.
- Out of order: 3 requests outstanding, responses on slots 2,0,1 -> commits carry the matching pc/rd of uuids 2,0,1 in that order; the slots become free.
- Backpressure: tex_req_ready=0 for 3 cycles -> tex_req fields are stable and exe_ready=0. commit_ready=0 -> tex_rsp_ready=0 and commit is stable until accepted.
- At full, response to slot 1 and exe_valid in the same cycle -> exe not accepted that cycle, accepted the next cycle into slot 1, pending_count stays 4.
- Reset with 2 in flight and commit_valid=1 -> next cycle commit_valid=0, tex_req_valid=0, pending_count=0; the next exe op gets slot 0.
